// File: rtl/interrogation_scheduler_if.sv
`timescale 1ns/1ps
// Control and handshake bundle shared by the register block, the interrogation
// scheduler and the SSR pulse generator.
interface interrogation_scheduler_if;
    logic        enable;
    logic [15:0] pattern_cfg;
    logic [2:0]  pattern_len;
    logic        no_p2_cfg;
    logic        err_clr;
    logic        start_STC;
    logic [3:0]  mode;
    logic        no_P2;
    logic        oddeven;
    logic        stop;
    logic        busy;
    logic [2:0]  slot;
    logic        err_timeout;
    logic        err_overrun;

    modport master (
        output enable, pattern_cfg, pattern_len, no_p2_cfg, err_clr, start_STC,
        input  mode, no_P2, oddeven, stop, busy, slot, err_timeout, err_overrun
    );

    modport slave (
        input  enable, pattern_cfg, pattern_len, no_p2_cfg, err_clr, start_STC,
        output mode, no_P2, oddeven, stop, busy, slot, err_timeout, err_overrun
    );
endinterface

// File: rtl/interrogation_scheduler.sv
`timescale 1ns/1ps
// Steps the pulse generator through the mode interlace pattern once per PRI,
// times the listening window and supervises STC timeout and PRI overrun.
module interrogation_scheduler #(
    parameter int unsigned PRI_CYCLES    = 5000,
    parameter int unsigned LISTEN_CYCLES = 4000,
    parameter int unsigned STC_TIMEOUT   = 1023
) (
    input  logic                     clk,
    input  logic                     rst,
    interrogation_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_STC,
        S_LISTEN,
        S_STOP,
        S_WAIT_PRI
    } state_e;

    localparam logic [15:0] PRI_LAST    = 16'(PRI_CYCLES - 1);
    localparam logic [15:0] LISTEN_LAST = 16'(LISTEN_CYCLES - 1);
    localparam logic [15:0] STC_LIMIT   = 16'(STC_TIMEOUT);

    state_e      state_q;
    logic [15:0] pri_cnt_q, pri_cnt_d;
    logic [15:0] phase_cnt_q;
    logic [15:0] shadow_cfg_q;
    logic [2:0]  shadow_len_q;
    logic        shadow_no_p2_q;
    logic [2:0]  slot_q;
    logic        first_q;
    logic        pending_q;
    logic [3:0]  mode_q;
    logic        no_p2_q;
    logic        oddeven_q;
    logic        stop_q;
    logic        busy_q;
    logic        err_timeout_q, err_timeout_d;
    logic        err_overrun_q, err_overrun_d;
    logic        pri_wrap;
    logic        timeout_hit;
    logic        overrun_hit;
    logic [3:0]  slot_mode;

    always_comb begin
        pri_wrap      = (pri_cnt_q == PRI_LAST);
        timeout_hit   = (state_q == S_WAIT_STC) && !bus.start_STC && (phase_cnt_q == STC_LIMIT);
        overrun_hit   = (state_q != S_IDLE) && (state_q != S_WAIT_PRI) && pri_wrap;
        pri_cnt_d     = ((state_q == S_IDLE) || pri_wrap) ? 16'd0 : pri_cnt_q + 16'd1;
        // A clear wins over a set landing in the same cycle.
        err_timeout_d = (err_timeout_q | timeout_hit) & ~bus.err_clr;
        err_overrun_d = (err_overrun_q | overrun_hit) & ~bus.err_clr;
        slot_mode     = 4'b0001 << shadow_cfg_q[{slot_q, 1'b0} +: 2];
    end

    // NOTE: state and outputs use non-blocking assignments so every register samples
    // pre-edge values; the synchronous reset covers every register, shadows included.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            pri_cnt_q      <= '0;
            phase_cnt_q    <= '0;
            shadow_cfg_q   <= '0;
            shadow_len_q   <= '0;
            shadow_no_p2_q <= 1'b0;
            slot_q         <= '0;
            first_q        <= 1'b0;
            pending_q      <= 1'b0;
            mode_q         <= '0;
            no_p2_q        <= 1'b0;
            oddeven_q      <= 1'b0;
            stop_q         <= 1'b0;
            busy_q         <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_overrun_q  <= 1'b0;
        end else begin
            pri_cnt_q     <= pri_cnt_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
            stop_q        <= 1'b0;
            if (overrun_hit) begin
                pending_q <= 1'b1;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (bus.enable) begin
                        state_q        <= S_ARM;
                        busy_q         <= 1'b1;
                        shadow_cfg_q   <= bus.pattern_cfg;
                        shadow_len_q   <= bus.pattern_len;
                        shadow_no_p2_q <= bus.no_p2_cfg;
                        slot_q         <= '0;
                        oddeven_q      <= 1'b0;
                        first_q        <= 1'b1;
                        pending_q      <= 1'b0;
                    end
                end

                S_ARM: begin
                    mode_q      <= slot_mode;
                    no_p2_q     <= shadow_no_p2_q;
                    first_q     <= 1'b0;
                    phase_cnt_q <= '0;
                    state_q     <= S_WAIT_STC;
                    if (!first_q) begin
                        oddeven_q <= ~oddeven_q;
                    end
                end

                S_WAIT_STC: begin
                    if (bus.start_STC) begin
                        mode_q      <= '0;
                        no_p2_q     <= 1'b0;
                        phase_cnt_q <= '0;
                        state_q     <= S_LISTEN;
                    end else if (phase_cnt_q == STC_LIMIT) begin
                        stop_q  <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        phase_cnt_q <= phase_cnt_q + 16'd1;
                        // Request drops after STC_TIMEOUT cycles; the stop follows one cycle later.
                        if (phase_cnt_q + 16'd1 == STC_LIMIT) begin
                            mode_q  <= '0;
                            no_p2_q <= 1'b0;
                        end
                    end
                end

                S_LISTEN: begin
                    if (phase_cnt_q == LISTEN_LAST) begin
                        stop_q  <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        phase_cnt_q <= phase_cnt_q + 16'd1;
                    end
                end

                S_STOP: begin
                    state_q <= S_WAIT_PRI;
                    if (slot_q == shadow_len_q) begin
                        slot_q         <= '0;
                        shadow_cfg_q   <= bus.pattern_cfg;
                        shadow_len_q   <= bus.pattern_len;
                        shadow_no_p2_q <= bus.no_p2_cfg;
                    end else begin
                        slot_q <= slot_q + 3'd1;
                    end
                end

                S_WAIT_PRI: begin
                    if (!bus.enable) begin
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        pending_q <= 1'b0;
                    end else if (pending_q || pri_wrap) begin
                        state_q   <= S_ARM;
                        pending_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mode        = mode_q;
    assign bus.no_P2       = no_p2_q;
    assign bus.oddeven     = oddeven_q;
    assign bus.stop        = stop_q;
    assign bus.busy        = busy_q;
    assign bus.slot        = slot_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.err_overrun = err_overrun_q;

endmodule
